// File: rtl/prog_ctrl_pkg.sv
// Shared opcodes, ALU selects and FSM state encoding for the program controller.
package prog_ctrl_pkg;
   localparam int OP_NOOP  = 0;
   localparam int OP_STORE = 1;
   localparam int OP_LOAD  = 2;
   localparam int OP_ADD   = 3;
   localparam int OP_SUB   = 4;
   localparam int OP_HALT  = 5;
   localparam int OP_JMPZ  = 6;

   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;

   typedef enum logic [3:0] {
      S_INIT, S_FETCH, S_DECODE, S_NOOP, S_LOAD_A, S_LOAD_B,
      S_STORE, S_ADD, S_SUB, S_JMPZ_A, S_JMPZ_B, S_HALT
   } state_t;
endpackage

// File: rtl/prog_ctrl_if.sv
// Controller <-> datapath bundle: IR contents and status in, datapath controls out.
interface prog_ctrl_if #(
   parameter int OP_W    = 4,
   parameter int REG_AW  = 4,
   parameter int DATA_AW = 8,
   parameter int ALU_SW  = 3
);
   localparam int INSTR_W = OP_W + REG_AW + DATA_AW;

   logic [INSTR_W-1:0] instruction;
   logic               rf_ra_zero;
   logic               resume;
   logic               PC_clr, PC_up, PC_ld, IR_ld;
   logic [DATA_AW-1:0] D_addr;
   logic               D_wr;
   logic               RF_s;
   logic [REG_AW-1:0]  RF_W_addr;
   logic               RF_W_wr;
   logic [REG_AW-1:0]  RF_Ra_addr;
   logic               RF_Ra_rd;
   logic [REG_AW-1:0]  RF_Rb_addr;
   logic               RF_Rb_rd;
   logic [ALU_SW-1:0]  Alu_s0;
   logic               halted;
   logic               illegal_op;

   modport master (
      input  instruction, rf_ra_zero, resume,
      output PC_clr, PC_up, PC_ld, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_wr,
             RF_Ra_addr, RF_Ra_rd, RF_Rb_addr, RF_Rb_rd, Alu_s0, halted, illegal_op
   );

   modport slave (
      output instruction, rf_ra_zero, resume,
      input  PC_clr, PC_up, PC_ld, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_wr,
             RF_Ra_addr, RF_Ra_rd, RF_Rb_addr, RF_Rb_rd, Alu_s0, halted, illegal_op
   );
endinterface

// File: rtl/prog_ctrl_decode.sv
// Combinational IR field extractor. PROG_CTRL_JMPZ_EN makes opcode 6 legal.
import prog_ctrl_pkg::*;

module prog_ctrl_decode #(
   parameter int OP_W    = 4,
   parameter int REG_AW  = 4,
   parameter int DATA_AW = 8,
   parameter int INSTR_W = OP_W + REG_AW + DATA_AW
) (
   input  logic [INSTR_W-1:0] instruction,
   output logic [OP_W-1:0]    opcode,
   output logic [REG_AW-1:0]  rd,
   output logic [REG_AW-1:0]  ra,
   output logic [REG_AW-1:0]  rb,
   output logic [DATA_AW-1:0] addr,
   output logic               legal
);
   assign opcode = instruction[INSTR_W-1 -: OP_W];
   assign rd     = instruction[DATA_AW+REG_AW-1 -: REG_AW];
   assign addr   = instruction[DATA_AW-1:0];
   assign ra     = addr[2*REG_AW-1 -: REG_AW];
   assign rb     = addr[REG_AW-1:0];

   always_comb begin
      legal = (opcode <= OP_W'(OP_HALT));
`ifdef PROG_CTRL_JMPZ_EN
      if (opcode == OP_W'(OP_JMPZ)) legal = 1'b1;
`endif
   end
endmodule

// File: rtl/prog_ctrl.sv
// Instruction-sequencing FSM with Moore output decode.
// PROG_CTRL_JMPZ_EN enables the conditional jump (JMPZ_A/JMPZ_B path, PC_ld).
import prog_ctrl_pkg::*;

module prog_ctrl #(
   parameter int OP_W    = 4,
   parameter int REG_AW  = 4,
   parameter int DATA_AW = 8,
   parameter int ALU_SW  = 3
) (
   input logic        clk,
   input logic        reset,
   prog_ctrl_if.master bus
);
   localparam int INSTR_W = OP_W + REG_AW + DATA_AW;

   state_t             state_q, state_d;
   logic [OP_W-1:0]    opcode;
   logic [REG_AW-1:0]  rd, ra, rb;
   logic [DATA_AW-1:0] addr;
   logic               legal;

   prog_ctrl_decode #(.OP_W(OP_W), .REG_AW(REG_AW), .DATA_AW(DATA_AW), .INSTR_W(INSTR_W)) u_dec (
      .instruction (bus.instruction),
      .opcode      (opcode),
      .rd          (rd),
      .ra          (ra),
      .rb          (rb),
      .addr        (addr),
      .legal       (legal)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_INIT;
      else       state_q <= state_d;
   end

   // Unused encodings and X both fall through to default and recover to INIT.
   always_comb begin
      state_d = S_INIT;
      case (state_q)
         S_INIT:   state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            state_d = S_NOOP;
            if (legal) begin
               case (opcode)
                  OP_W'(OP_STORE): state_d = S_STORE;
                  OP_W'(OP_LOAD):  state_d = S_LOAD_A;
                  OP_W'(OP_ADD):   state_d = S_ADD;
                  OP_W'(OP_SUB):   state_d = S_SUB;
                  OP_W'(OP_HALT):  state_d = S_HALT;
`ifdef PROG_CTRL_JMPZ_EN
                  OP_W'(OP_JMPZ):  state_d = S_JMPZ_A;
`endif
                  default:         state_d = S_NOOP;
               endcase
            end
         end
         S_LOAD_A: state_d = S_LOAD_B;
         S_JMPZ_A: state_d = S_JMPZ_B;
         S_LOAD_B, S_STORE, S_ADD, S_SUB, S_NOOP, S_JMPZ_B: state_d = S_FETCH;
         S_HALT:   state_d = bus.resume ? S_FETCH : S_HALT;
         default:  state_d = S_INIT;
      endcase
   end

   always_comb begin
      bus.PC_clr     = 1'b0;
      bus.PC_up      = 1'b0;
      bus.PC_ld      = 1'b0;
      bus.IR_ld      = 1'b0;
      bus.D_addr     = '0;
      bus.D_wr       = 1'b0;
      bus.RF_s       = 1'b0;
      bus.RF_W_addr  = '0;
      bus.RF_W_wr    = 1'b0;
      bus.RF_Ra_addr = '0;
      bus.RF_Ra_rd   = 1'b0;
      bus.RF_Rb_addr = '0;
      bus.RF_Rb_rd   = 1'b0;
      bus.Alu_s0     = ALU_SW'(ALU_PASS);
      bus.halted     = 1'b0;
      bus.illegal_op = 1'b0;
      case (state_q)
         S_INIT:   bus.PC_clr = 1'b1;
         S_FETCH:  begin bus.IR_ld = 1'b1; bus.PC_up = 1'b1; end
         S_NOOP:   bus.illegal_op = ~legal;
         S_LOAD_A: bus.D_addr = addr;
         S_LOAD_B: begin
            bus.D_addr    = addr;
            bus.RF_s      = 1'b1;
            bus.RF_W_addr = rd;
            bus.RF_W_wr   = 1'b1;
         end
         S_STORE:  begin
            bus.D_addr     = addr;
            bus.D_wr       = 1'b1;
            bus.RF_Ra_addr = rd;
            bus.RF_Ra_rd   = 1'b1;
         end
         S_ADD, S_SUB: begin
            bus.RF_Ra_addr = ra;
            bus.RF_Rb_addr = rb;
            bus.RF_Ra_rd   = 1'b1;
            bus.RF_Rb_rd   = 1'b1;
            bus.RF_W_addr  = rd;
            bus.RF_W_wr    = 1'b1;
            bus.Alu_s0     = (state_q == S_ADD) ? ALU_SW'(ALU_ADD) : ALU_SW'(ALU_SUB);
         end
         S_JMPZ_A: begin bus.RF_Ra_addr = rd; bus.RF_Ra_rd = 1'b1; end
         S_JMPZ_B: begin
            bus.D_addr = addr;
`ifdef PROG_CTRL_JMPZ_EN
            bus.PC_ld  = bus.rf_ra_zero;
`endif
         end
         S_HALT:   bus.halted = 1'b1;
         default:  ;
      endcase
   end

   // Without the jump feature the zero flag has no consumer.
   logic unused_zero;
   assign unused_zero = bus.rf_ra_zero;
endmodule

// File: tb/tb_prog_ctrl.sv
// Self-checking bench for prog_ctrl: directed scenarios plus random instruction stream.
module tb_prog_ctrl;
   typedef struct packed {
      logic       pc_clr, pc_up, pc_ld, ir_ld;
      logic [7:0] d_addr;
      logic       d_wr, rf_s;
      logic [3:0] w_addr;
      logic       w_wr;
      logic [3:0] ra_addr;
      logic       ra_rd;
      logic [3:0] rb_addr;
      logic       rb_rd;
      logic [2:0] alu;
      logic       halted, illegal;
   } out_t;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   out_t exp_q[$];

   prog_ctrl_if bus ();
   prog_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   function automatic out_t sample();
      out_t o;
      o.pc_clr  = bus.PC_clr;     o.pc_up   = bus.PC_up;
      o.pc_ld   = bus.PC_ld;      o.ir_ld   = bus.IR_ld;
      o.d_addr  = bus.D_addr;     o.d_wr    = bus.D_wr;
      o.rf_s    = bus.RF_s;       o.w_addr  = bus.RF_W_addr;
      o.w_wr    = bus.RF_W_wr;    o.ra_addr = bus.RF_Ra_addr;
      o.ra_rd   = bus.RF_Ra_rd;   o.rb_addr = bus.RF_Rb_addr;
      o.rb_rd   = bus.RF_Rb_rd;   o.alu     = bus.Alu_s0;
      o.halted  = bus.halted;     o.illegal = bus.illegal_op;
      return o;
   endfunction

   function automatic out_t rec_init();
      out_t o = '0; o.pc_clr = 1'b1; return o;
   endfunction

   function automatic out_t rec_fetch();
      out_t o = '0; o.ir_ld = 1'b1; o.pc_up = 1'b1; return o;
   endfunction

   function automatic out_t rec_halt();
      out_t o = '0; o.halted = 1'b1; return o;
   endfunction

   // Expected per-cycle outputs from DECODE to the end of execute, built from the ISA rules.
   function automatic void model(input logic [15:0] ir, input logic z);
      int unsigned op   = ir >> 12;
      logic [3:0]  rd   = 4'((ir >> 8) & 16'hF);
      logic [7:0]  addr = 8'(ir & 16'hFF);
      out_t o;
      exp_q.delete();
      exp_q.push_back('0);
      o = '0;
      case (op)
         0: exp_q.push_back(o);
         1: begin
            o.d_addr = addr; o.d_wr = 1; o.ra_addr = rd; o.ra_rd = 1;
            exp_q.push_back(o);
         end
         2: begin
            o.d_addr = addr; exp_q.push_back(o);
            o.rf_s = 1; o.w_addr = rd; o.w_wr = 1; exp_q.push_back(o);
         end
         3, 4: begin
            o.ra_addr = addr[7:4]; o.rb_addr = addr[3:0]; o.ra_rd = 1; o.rb_rd = 1;
            o.w_addr = rd; o.w_wr = 1; o.alu = (op == 3) ? 3'd1 : 3'd2;
            exp_q.push_back(o);
         end
`ifdef PROG_CTRL_JMPZ_EN
         6: begin
            o.ra_addr = rd; o.ra_rd = 1; exp_q.push_back(o);
            o = '0; o.d_addr = addr; o.pc_ld = z; exp_q.push_back(o);
         end
`endif
         default: begin o.illegal = 1; exp_q.push_back(o); end
      endcase
   endfunction

   // Entered at the negedge of a FETCH cycle; leaves at the negedge of the next FETCH.
   task automatic run_instr(input logic [15:0] ir, input logic z, input logic res, input string nm);
      out_t act, expv;
      bus.instruction = ir;
      bus.rf_ra_zero  = z;
      bus.resume      = res;
      model(ir, z);
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         act = sample(); expv = exp_q[i];
         checks++;
         if (act !== expv) begin
            errors++;
            $display("FAIL %s ir=%h cyc%0d got=%h exp=%h", nm, ir, i, act, expv);
         end
      end
      @(negedge clk);
      act = sample();
      checks++;
      if (act !== rec_fetch()) begin
         errors++;
         $display("FAIL %s_refetch ir=%h got=%h exp=%h", nm, ir, act, rec_fetch());
      end
      bus.resume = 1'b0;
   endtask

   task automatic test_reset();
      out_t act;
      reset = 1'b1;
      bus.instruction = '0; bus.rf_ra_zero = 1'b0; bus.resume = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         act = sample();
         checks++;
         if (act !== rec_init()) begin
            errors++;
            $display("FAIL reset_init cyc%0d got=%h exp=%h", i, act, rec_init());
         end
      end
      bus.resume = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      act = sample();
      checks++;
      if (act !== rec_fetch()) begin
         errors++;
         $display("FAIL reset_first_fetch got=%h exp=%h", act, rec_fetch());
      end
   endtask

   task automatic test_halt();
      out_t act;
      bus.instruction = 16'h5000;
      @(negedge clk);
      act = sample();
      checks++;
      if (act !== out_t'('0)) begin errors++; $display("FAIL halt_decode got=%h exp=0", act); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         act = sample();
         checks++;
         if (act !== rec_halt()) begin
            errors++;
            $display("FAIL halt_hold cyc%0d got=%h exp=%h", i, act, rec_halt());
         end
      end
      bus.resume = 1'b1;
      @(negedge clk);
      bus.resume = 1'b0;
      act = sample();
      checks++;
      if (act !== rec_fetch()) begin errors++; $display("FAIL halt_resume got=%h exp=%h", act, rec_fetch()); end
      // resume held across a second HALT: still enters HALT, then exits once
      bus.resume = 1'b1;
      @(negedge clk);
      @(negedge clk);
      act = sample();
      checks++;
      if (act !== rec_halt()) begin errors++; $display("FAIL halt_reenter got=%h exp=%h", act, rec_halt()); end
      @(negedge clk);
      act = sample();
      checks++;
      if (act !== rec_fetch()) begin errors++; $display("FAIL halt_reexit got=%h exp=%h", act, rec_fetch()); end
      bus.resume = 1'b0;
   endtask

   task automatic test_reset_mid_load();
      out_t act, la;
      la = '0; la.d_addr = 8'h1A;
      bus.instruction = 16'h231A;
      @(negedge clk);
      @(negedge clk);
      act = sample();
      checks++;
      if (act !== la) begin errors++; $display("FAIL midload_loada got=%h exp=%h", act, la); end
      reset = 1'b1;
      @(negedge clk);
      act = sample();
      checks++;
      if (act !== rec_init()) begin errors++; $display("FAIL midload_init got=%h exp=%h", act, rec_init()); end
      reset = 1'b0;
      @(negedge clk);
      act = sample();
      checks++;
      if (act !== rec_fetch()) begin errors++; $display("FAIL midload_fetch got=%h exp=%h", act, rec_fetch()); end
   endtask

   task automatic test_directed();
      run_instr(16'h231A, 1'b0, 1'b0, "load");
      run_instr(16'h3512, 1'b0, 1'b0, "add");
      run_instr(16'h4A9C, 1'b0, 1'b0, "sub");
      run_instr(16'h17C3, 1'b0, 1'b0, "store");
      run_instr(16'h6440, 1'b1, 1'b0, "jmpz_taken");
      run_instr(16'h6440, 1'b0, 1'b0, "jmpz_not");
      run_instr(16'hF000, 1'b0, 1'b0, "illegal");
      run_instr(16'h0000, 1'b1, 1'b1, "noop_resume_ignored");
   endtask

   task automatic test_random();
      logic [15:0] ir;
      for (int n = 0; n < 60; n++) begin
         ir = 16'($urandom);
         if (ir[15:12] == 4'd5) ir[15:12] = 4'd0;
         run_instr(ir, 1'($urandom), 1'($urandom), "rand");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_halt();
      test_reset_mid_load();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
